// File: rtl/picorv32_axi_bridge_if.sv
// AXI4-Lite bus between the picorv32 memory bridge (master) and system memory (slave).
// Signal names keep the core wrapper's mem_axi_ prefix so they line up with the wrapper ports.
interface picorv32_axi_bridge_if;
    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;

    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;

    logic        mem_axi_bvalid;
    logic        mem_axi_bready;

    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;

    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;

    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        output mem_axi_bready,
        output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        output mem_axi_rready,
        input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );

    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        input  mem_axi_bready,
        input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        input  mem_axi_rready,
        output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );
endinterface

// File: rtl/picorv32_axi_bridge.sv
// Converts the picorv32 native valid/ready memory bus into AXI4-Lite master transfers.
// One outstanding transfer; AW, W and AR handshake independently, responses pass through combinationally.
module picorv32_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    picorv32_axi_bridge_if.master axi
);
    logic is_wr;
    logic is_rd;
    logic ack_aw;
    logic ack_w;
    logic ack_ar;
    logic xfer_done;
    logic awvalid;
    logic wvalid;
    logic arvalid;
    logic bready;
    logic rready;

    assign is_wr = |mem_wstrb;
    assign is_rd = ~is_wr;

    // xfer_done masks everything for one cycle so a held mem_valid is not re-issued
    assign awvalid = mem_valid & is_wr & ~ack_aw & ~xfer_done;
    assign wvalid  = mem_valid & is_wr & ~ack_w  & ~xfer_done;
    assign arvalid = mem_valid & is_rd & ~ack_ar & ~xfer_done;
    assign bready  = mem_valid & is_wr & ~xfer_done;
    assign rready  = mem_valid & is_rd & ~xfer_done;

    assign mem_ready = (axi.mem_axi_bvalid & bready) | (axi.mem_axi_rvalid & rready);
    assign mem_rdata = axi.mem_axi_rdata;

    assign axi.mem_axi_awvalid = awvalid;
    assign axi.mem_axi_awaddr  = mem_addr;
    assign axi.mem_axi_awprot  = 3'b000;
    assign axi.mem_axi_wvalid  = wvalid;
    assign axi.mem_axi_wdata   = mem_wdata;
    assign axi.mem_axi_wstrb   = mem_wstrb;
    assign axi.mem_axi_bready  = bready;
    assign axi.mem_axi_arvalid = arvalid;
    assign axi.mem_axi_araddr  = mem_addr;
    assign axi.mem_axi_arprot  = mem_instr ? 3'b100 : 3'b000;
    assign axi.mem_axi_rready  = rready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_aw    <= 1'b0;
            ack_w     <= 1'b0;
            ack_ar    <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            xfer_done <= mem_valid & mem_ready;
            // clearing wins over a handshake landing in the same cycle
            if (!mem_valid || xfer_done) begin
                ack_aw <= 1'b0;
                ack_w  <= 1'b0;
                ack_ar <= 1'b0;
            end else begin
                if (awvalid && axi.mem_axi_awready) ack_aw <= 1'b1;
                if (wvalid  && axi.mem_axi_wready)  ack_w  <= 1'b1;
                if (arvalid && axi.mem_axi_arready) ack_ar <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_picorv32_axi_bridge.sv
// Directed and randomized-delay checks of the picorv32 AXI4-Lite bridge.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_picorv32_axi_bridge;
    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    picorv32_axi_bridge_if bus ();

    picorv32_axi_bridge dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .axi       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        bus.mem_axi_awready = 1'b0;
        bus.mem_axi_wready  = 1'b0;
        bus.mem_axi_bvalid  = 1'b0;
        bus.mem_axi_arready = 1'b0;
        bus.mem_axi_rvalid  = 1'b0;
        bus.mem_axi_rdata   = 32'h0;
    endtask

    task automatic check_bus_quiet(input string tag);
        check({tag, "_aw"}, {31'h0, bus.mem_axi_awvalid}, 32'h0);
        check({tag, "_w"},  {31'h0, bus.mem_axi_wvalid},  32'h0);
        check({tag, "_ar"}, {31'h0, bus.mem_axi_arvalid}, 32'h0);
        check({tag, "_b"},  {31'h0, bus.mem_axi_bready},  32'h0);
        check({tag, "_r"},  {31'h0, bus.mem_axi_rready},  32'h0);
        check({tag, "_rdy"},{31'h0, mem_ready},           32'h0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) res[8*b +: 8] = d[8*b +: 8];
        return res;
    endfunction

    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem   [16];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        is_w, a_seen, w_seen, done, both_prev;
        logic [3:0]  idx, cap_a, st, cap_ws;
        logic [31:0] wd, cap_wd;
        int          d_a, d_w, d_r, t, rsp_cnt;

        resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        slave_idle();
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = (i * 32'h0101_0101) ^ 32'ha5a5_0000;
            ref_mem[i]   = (i * 32'h0101_0101) ^ 32'ha5a5_0000;
        end

        // reset
        repeat (3) @(negedge clk);
        #1 check_bus_quiet("reset");
        @(negedge clk); resetn = 1'b1;
        #1 check_bus_quiet("post_reset");

        // instruction fetch, data one cycle after AR
        @(negedge clk);
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0;
        bus.mem_axi_arready = 1'b1;
        #1;
        check("fetch_arvalid", {31'h0, bus.mem_axi_arvalid}, 32'h1);
        check("fetch_arprot",  {29'h0, bus.mem_axi_arprot},  32'h4);
        check("fetch_araddr",  bus.mem_axi_araddr,           32'h0000_0100);
        check("fetch_awvalid", {31'h0, bus.mem_axi_awvalid}, 32'h0);
        check("fetch_early",   {31'h0, mem_ready},           32'h0);
        @(negedge clk);
        bus.mem_axi_arready = 1'b0; bus.mem_axi_rvalid = 1'b1; bus.mem_axi_rdata = 32'h1234_5678;
        #1;
        check("fetch_ar_drop", {31'h0, bus.mem_axi_arvalid}, 32'h0);
        check("fetch_ready",   {31'h0, mem_ready},           32'h1);
        check("fetch_rdata",   mem_rdata,                    32'h1234_5678);
        @(negedge clk);
        mem_valid = 1'b0; mem_instr = 1'b0; slave_idle();
        #1 check_bus_quiet("fetch_end");

        // word write: AW cycle 1, W cycle 3, B cycle 4
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_8da4; mem_wdata = 32'hdeadbeef; mem_wstrb = 4'hf;
        bus.mem_axi_awready = 1'b1;
        #1;
        check("wr_c1_aw",     {31'h0, bus.mem_axi_awvalid}, 32'h1);
        check("wr_c1_w",      {31'h0, bus.mem_axi_wvalid},  32'h1);
        check("wr_awaddr",    bus.mem_axi_awaddr,           32'h0000_8da4);
        check("wr_wdata",     bus.mem_axi_wdata,            32'hdeadbeef);
        check("wr_wstrb",     {28'h0, bus.mem_axi_wstrb},   32'hf);
        check("wr_ar",        {31'h0, bus.mem_axi_arvalid}, 32'h0);
        check("wr_bready",    {31'h0, bus.mem_axi_bready},  32'h1);
        check("wr_c1_rdy",    {31'h0, mem_ready},           32'h0);
        @(negedge clk);
        bus.mem_axi_awready = 1'b0;
        #1;
        check("wr_c2_aw",     {31'h0, bus.mem_axi_awvalid}, 32'h0);
        check("wr_c2_w",      {31'h0, bus.mem_axi_wvalid},  32'h1);
        check("wr_c2_rdy",    {31'h0, mem_ready},           32'h0);
        @(negedge clk);
        bus.mem_axi_wready = 1'b1;
        #1;
        check("wr_c3_aw",     {31'h0, bus.mem_axi_awvalid}, 32'h0);
        check("wr_c3_w",      {31'h0, bus.mem_axi_wvalid},  32'h1);
        check("wr_c3_rdy",    {31'h0, mem_ready},           32'h0);
        @(negedge clk);
        bus.mem_axi_wready = 1'b0; bus.mem_axi_bvalid = 1'b1;
        #1;
        check("wr_c4_w",      {31'h0, bus.mem_axi_wvalid},  32'h0);
        check("wr_c4_aw",     {31'h0, bus.mem_axi_awvalid}, 32'h0);
        check("wr_c4_rdy",    {31'h0, mem_ready},           32'h1);
        @(negedge clk);
        mem_valid = 1'b0; slave_idle();
        #1 check_bus_quiet("wr_end");

        // byte write, AW and W together, slave keeps readies high
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0022; mem_wdata = 32'h00ab_0000; mem_wstrb = 4'b0100;
        bus.mem_axi_awready = 1'b1; bus.mem_axi_wready = 1'b1;
        #1;
        check("bw_aw",        {31'h0, bus.mem_axi_awvalid}, 32'h1);
        check("bw_w",         {31'h0, bus.mem_axi_wvalid},  32'h1);
        check("bw_awprot",    {29'h0, bus.mem_axi_awprot},  32'h0);
        check("bw_wstrb",     {28'h0, bus.mem_axi_wstrb},   32'h4);
        @(negedge clk);
        #1;
        check("bw_dup_aw",    {31'h0, bus.mem_axi_awvalid}, 32'h0);
        check("bw_dup_w",     {31'h0, bus.mem_axi_wvalid},  32'h0);
        check("bw_early",     {31'h0, mem_ready},           32'h0);
        @(negedge clk);
        bus.mem_axi_bvalid = 1'b1;
        #1;
        check("bw_ready",     {31'h0, mem_ready},           32'h1);
        check("bw_dup_aw2",   {31'h0, bus.mem_axi_awvalid}, 32'h0);
        @(negedge clk);
        mem_valid = 1'b0; slave_idle();
        #1 check_bus_quiet("bw_end");

        // back-to-back reads with mem_valid held high
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0200; mem_wstrb = 4'h0;
        bus.mem_axi_arready = 1'b1;
        #1 check("b2b_ar1",   {31'h0, bus.mem_axi_arvalid}, 32'h1);
        @(negedge clk);
        bus.mem_axi_arready = 1'b0; bus.mem_axi_rvalid = 1'b1; bus.mem_axi_rdata = 32'h1111_2222;
        #1;
        check("b2b_rdy1",     {31'h0, mem_ready},           32'h1);
        check("b2b_rdata1",   mem_rdata,                    32'h1111_2222);
        @(negedge clk);
        mem_addr = 32'h0000_0204; bus.mem_axi_rvalid = 1'b1; bus.mem_axi_arready = 1'b1;
        #1;
        check("b2b_bubble_ar",{31'h0, bus.mem_axi_arvalid}, 32'h0);
        check("b2b_bubble_r", {31'h0, bus.mem_axi_rready},  32'h0);
        check("b2b_bubble_rdy",{31'h0, mem_ready},          32'h0);
        @(negedge clk);
        bus.mem_axi_rvalid = 1'b0;
        #1;
        check("b2b_ar2",      {31'h0, bus.mem_axi_arvalid}, 32'h1);
        check("b2b_araddr2",  bus.mem_axi_araddr,           32'h0000_0204);
        @(negedge clk);
        bus.mem_axi_arready = 1'b0; bus.mem_axi_rvalid = 1'b1; bus.mem_axi_rdata = 32'h3333_4444;
        #1;
        check("b2b_rdy2",     {31'h0, mem_ready},           32'h1);
        check("b2b_rdata2",   mem_rdata,                    32'h3333_4444);
        @(negedge clk);
        mem_valid = 1'b0; slave_idle();
        #1 check_bus_quiet("b2b_end");

        // reset with AW accepted and W pending
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = 32'hcafe_f00d; mem_wstrb = 4'hf;
        bus.mem_axi_awready = 1'b1;
        #1 check("rst_aw_first",{31'h0, bus.mem_axi_awvalid}, 32'h1);
        @(negedge clk);
        bus.mem_axi_awready = 1'b0;
        #1;
        check("rst_aw_acked", {31'h0, bus.mem_axi_awvalid}, 32'h0);
        check("rst_w_pend",   {31'h0, bus.mem_axi_wvalid},  32'h1);
        resetn = 1'b0;
        #1;
        // mem_valid still high: awvalid reappears only if ack_aw cleared without a clock
        check("rst_async_clr",{31'h0, bus.mem_axi_awvalid}, 32'h1);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        #1 check_bus_quiet("rst_hold");
        @(negedge clk); resetn = 1'b1;
        #1 check_bus_quiet("rst_release");
        @(negedge clk);
        #1 check_bus_quiet("rst_idle");

        // randomized slave delays over mixed transfers
        for (int n = 0; n < 1000; n++) begin
            is_w = 1'($urandom_range(0, 1));
            idx  = 4'($urandom_range(0, 15));
            wd   = $urandom;
            st   = is_w ? 4'($urandom_range(1, 15)) : 4'h0;
            d_a  = $urandom_range(0, 4);
            d_w  = $urandom_range(0, 4);
            d_r  = $urandom_range(0, 4);
            @(negedge clk);
            mem_valid = 1'b1; mem_instr = ~is_w & 1'($urandom_range(0, 1));
            mem_addr  = 32'h0000_1000 | {26'h0, idx, 2'b00};
            mem_wdata = wd; mem_wstrb = st;
            a_seen = 1'b0; w_seen = 1'b0; done = 1'b0; t = 0; rsp_cnt = 0;
            cap_a = 4'h0; cap_wd = 32'h0; cap_ws = 4'h0;
            while (!done && t < 40) begin
                bus.mem_axi_awready = is_w & (t >= d_a);
                bus.mem_axi_wready  = is_w & (t >= d_w);
                bus.mem_axi_arready = ~is_w & (t >= d_a);
                bus.mem_axi_bvalid  = is_w & a_seen & w_seen & (rsp_cnt >= d_r);
                bus.mem_axi_rvalid  = ~is_w & a_seen & (rsp_cnt >= d_r);
                bus.mem_axi_rdata   = bus.mem_axi_rvalid ? slave_mem[cap_a] : 32'h0;
                if (is_w && bus.mem_axi_bvalid)
                    slave_mem[cap_a] = merge(slave_mem[cap_a], cap_wd, cap_ws);
                #1;
                check("rnd_awvalid", {31'h0, bus.mem_axi_awvalid}, {31'h0, is_w & ~a_seen});
                check("rnd_wvalid",  {31'h0, bus.mem_axi_wvalid},  {31'h0, is_w & ~w_seen});
                check("rnd_arvalid", {31'h0, bus.mem_axi_arvalid}, {31'h0, ~is_w & ~a_seen});
                check("rnd_ready",   {31'h0, mem_ready},
                      {31'h0, bus.mem_axi_bvalid | bus.mem_axi_rvalid});
                if (bus.mem_axi_bvalid || bus.mem_axi_rvalid) begin
                    done = 1'b1;
                    if (!is_w) check("rnd_rdata", mem_rdata, ref_mem[idx]);
                    else       ref_mem[idx] = merge(ref_mem[idx], wd, st);
                end
                both_prev = is_w ? (a_seen & w_seen) : a_seen;
                if (bus.mem_axi_awvalid && bus.mem_axi_awready) begin
                    a_seen = 1'b1; cap_a = bus.mem_axi_awaddr[5:2];
                end
                if (bus.mem_axi_arvalid && bus.mem_axi_arready) begin
                    a_seen = 1'b1; cap_a = bus.mem_axi_araddr[5:2];
                end
                if (bus.mem_axi_wvalid && bus.mem_axi_wready) begin
                    w_seen = 1'b1; cap_wd = bus.mem_axi_wdata; cap_ws = bus.mem_axi_wstrb;
                end
                if (both_prev) rsp_cnt++;
                t++;
                @(negedge clk);
            end
            if (!done) check("rnd_timeout", 32'h0, 32'h1);
            mem_valid = 1'b0; slave_idle();
            #1 check("rnd_single_rdy", {31'h0, mem_ready}, 32'h0);
        end

        // slave memory built from what the bridge put on AXI must match the core's view
        for (int i = 0; i < 16; i++)
            check("rnd_mem_final", slave_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
